// File: rtl/jram_sequencer.sv
// jram_sequencer: two-requester round-robin controller driving the jRAM
// control pins (MAR address, MAR set, RAM set, RAM enable).
// Every access runs MAR -> STROBE (STROBE_CYCLES) -> RESP -> IDLE.
// All jRAM-facing outputs, RSP_* and BUSY are registered from the next
// state so that no combinational glitch reaches the gate-level latches.
// REQ_READY is the only combinational output.
// Optional build macro JRAM_SEQ_CLEAR_EN: after reset, sweep zeros into every
// address before entering IDLE.
module jram_sequencer #(
  parameter int unsigned STROBE_CYCLES = 1,
  parameter int unsigned AW            = 8,
  parameter int unsigned DW            = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [1:0]        REQ_VALID,
  input  logic [1:0]        REQ_WE,
  input  logic [2*AW-1:0]   REQ_ADDR,
  input  logic [2*DW-1:0]   REQ_WDATA,
  output logic [1:0]        REQ_READY,
  output logic [1:0]        RSP_VALID,
  output logic [DW-1:0]     RSP_DATA,
  output logic              BUSY,
  output logic [AW-1:0]     RAM_MAR,
  output logic              RAM_SA,
  output logic [DW-1:0]     RAM_BUS_OUT,
  output logic              RAM_S,
  output logic              RAM_E,
  input  logic [DW-1:0]     RAM_BUS_IN
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAR,
    ST_STROBE,
    ST_RESP
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(STROBE_CYCLES - 1);

  state_t          state_q, state_d;
  logic            rr_q, rr_d;
  logic            gnt_q, gnt_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [3:0]      cnt_q, cnt_d;

  logic [AW-1:0]   mar_q, mar_d;
  logic            sa_q, sa_d;
  logic            s_q, s_d;
  logic            e_q, e_d;
  logic [DW-1:0]   bus_out_q, bus_out_d;
  logic [1:0]      rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic            busy_q, busy_d;

  logic            gsel;
  logic            sweep_pending;

`ifdef JRAM_SEQ_CLEAR_EN
  logic            sweep_q, sweep_d;
  logic            clr_done_q, clr_done_d;
  assign sweep_pending = !clr_done_q;
`else
  assign sweep_pending = 1'b0;
`endif

  assign RAM_MAR     = mar_q;
  assign RAM_SA      = sa_q;
  assign RAM_S       = s_q;
  assign RAM_E       = e_q;
  assign RAM_BUS_OUT = bus_out_q;
  assign RSP_VALID   = rsp_valid_q;
  assign RSP_DATA    = rsp_data_q;
  assign BUSY        = busy_q;

  // Next-state, grant and next registered-output values.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    mar_d       = mar_q;
    sa_d        = 1'b0;
    s_d         = 1'b0;
    e_d         = 1'b0;
    bus_out_d   = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    busy_d      = 1'b0;
    REQ_READY   = '0;
    gsel        = rr_q;
`ifdef JRAM_SEQ_CLEAR_EN
    sweep_d     = sweep_q;
    clr_done_d  = clr_done_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (sweep_pending) begin
`ifdef JRAM_SEQ_CLEAR_EN
          // Clear sweep reuses the write path with a latched zero write.
          sweep_d = 1'b1;
          we_d    = 1'b1;
          wdata_d = '0;
          addr_d  = '0;
          state_d = ST_MAR;
`endif
        end else if (!RESET && (REQ_VALID != 2'b00)) begin
          gsel            = (REQ_VALID == 2'b11) ? rr_q : REQ_VALID[1];
          REQ_READY[gsel] = 1'b1;
          gnt_d           = gsel;
          we_d            = REQ_WE[gsel];
          addr_d          = gsel ? REQ_ADDR[2*AW-1:AW]  : REQ_ADDR[AW-1:0];
          wdata_d         = gsel ? REQ_WDATA[2*DW-1:DW] : REQ_WDATA[DW-1:0];
          state_d         = ST_MAR;
        end
      end
      ST_MAR: begin
        cnt_d   = CNT_LOAD;
        state_d = ST_STROBE;
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          if (!we_q) rdata_d = RAM_BUS_IN;
`ifdef JRAM_SEQ_CLEAR_EN
          if (sweep_q) begin
            if (addr_q == '1) begin
              sweep_d    = 1'b0;
              clr_done_d = 1'b1;
              state_d    = ST_IDLE;
            end else begin
              addr_d  = addr_q + AW'(1);
              state_d = ST_MAR;
            end
          end else
`endif
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        rr_d    = ~gnt_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the state being entered so they register
    // in step with it.
    busy_d = (state_d != ST_IDLE);
    case (state_d)
      ST_MAR: begin
        mar_d = addr_d;
        sa_d  = 1'b1;
      end
      ST_STROBE: begin
        if (we_d) begin
          s_d       = 1'b1;
          bus_out_d = wdata_d;
        end else begin
          e_d = 1'b1;
        end
      end
      ST_RESP: begin
        rsp_valid_d[gnt_d] = 1'b1;
        rsp_data_d         = we_d ? wdata_d : rdata_d;
      end
      default: ;
    endcase
  end

  // State and registered outputs; synchronous active-high reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      rr_q        <= 1'b0;
      gnt_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      cnt_q       <= '0;
      mar_q       <= '0;
      sa_q        <= 1'b0;
      s_q         <= 1'b0;
      e_q         <= 1'b0;
      bus_out_q   <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
`ifdef JRAM_SEQ_CLEAR_EN
      sweep_q     <= 1'b0;
      clr_done_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
      mar_q       <= mar_d;
      sa_q        <= sa_d;
      s_q         <= s_d;
      e_q         <= e_d;
      bus_out_q   <= bus_out_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
`ifdef JRAM_SEQ_CLEAR_EN
      sweep_q     <= sweep_d;
      clr_done_q  <= clr_done_d;
`endif
    end
  end

endmodule

// File: tb/tb_jram_sequencer.sv
// Testbench for jram_sequencer: two instances (STROBE_CYCLES=1 and 3) share
// one stimulus stream; each is checked cycle by cycle against a
// transaction-level timing model and a shadow of the jRAM contents.
module tb_jram_sequencer;

`ifdef JRAM_SEQ_CLEAR_EN
  localparam bit CLR     = 1'b1;
  localparam int RST_DEN = 4000;
  localparam int NRAND   = 12000;
`else
  localparam bit CLR     = 1'b0;
  localparam int RST_DEN = 60;
  localparam int NRAND   = 3000;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] v, w;
  logic [7:0] a0, a1, d0, d1;

  logic [1:0] rdy [2];
  logic [1:0] rv  [2];
  logic [7:0] rd  [2];
  logic [7:0] mar [2];
  logic [7:0] bo  [2];
  logic [7:0] bi  [2];
  logic       busy[2];
  logic       sa  [2];
  logic       s   [2];
  logic       e   [2];

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  jram_sequencer #(.STROBE_CYCLES(1), .AW(8), .DW(8)) u_dut0 (
    .CLK(clk), .RESET(rst), .REQ_VALID(v), .REQ_WE(w),
    .REQ_ADDR({a1, a0}), .REQ_WDATA({d1, d0}),
    .REQ_READY(rdy[0]), .RSP_VALID(rv[0]), .RSP_DATA(rd[0]), .BUSY(busy[0]),
    .RAM_MAR(mar[0]), .RAM_SA(sa[0]), .RAM_BUS_OUT(bo[0]),
    .RAM_S(s[0]), .RAM_E(e[0]), .RAM_BUS_IN(bi[0])
  );

  jram_sequencer #(.STROBE_CYCLES(3), .AW(8), .DW(8)) u_dut1 (
    .CLK(clk), .RESET(rst), .REQ_VALID(v), .REQ_WE(w),
    .REQ_ADDR({a1, a0}), .REQ_WDATA({d1, d0}),
    .REQ_READY(rdy[1]), .RSP_VALID(rv[1]), .RSP_DATA(rd[1]), .BUSY(busy[1]),
    .RAM_MAR(mar[1]), .RAM_SA(sa[1]), .RAM_BUS_OUT(bo[1]),
    .RAM_S(s[1]), .RAM_E(e[1]), .RAM_BUS_IN(bi[1])
  );

  // Stand-in jRAM per instance: written on RAM_S, read onto the bus on RAM_E.
  logic [7:0] mem [2][256];
  logic       mem_init_done = 1'b0;
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int a = 0; a < 256; a++) begin
        mem[0][a] <= 8'(a * 37 + 11);
        mem[1][a] <= 8'(a * 37 + 11);
      end
      mem_init_done <= 1'b1;
    end else begin
      for (int k = 0; k < 2; k++)
        if (s[k]) mem[k][mar[k]] <= bo[k];
    end
  end
  assign bi[0] = e[0] ? mem[0][mar[0]] : 8'h00;
  assign bi[1] = e[1] ? mem[1][mar[1]] : 8'h00;

  // Reference model state, per instance.
  int         ph  [2];   // -1 idle, else cycles since acceptance (0 = MAR)
  int         sw  [2];   // -1 no sweep, else cycle index into clear sweep
  bit         clrp[2];   // sweep starts at next edge
  bit         acc [2];
  logic       g   [2];
  logic       rr  [2];
  logic       mwe [2];
  logic [7:0] maddr[2], mwd[2], mrdata[2], e_mar[2], e_rspd[2];
  logic [7:0] shadow[2][256];

  function automatic int sc(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    logic       gg;
    logic [1:0] erdy, erv;
    logic       esa, es, ee, ebusy;
    logic [7:0] ebo;
    int         S;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      erdy   = 2'b00;
      acc[k] = 1'b0;
      if (!rst && ph[k] == -1 && sw[k] == -1 && !clrp[k] && v != 2'b00) begin
        gg       = (v == 2'b11) ? rr[k] : v[1];
        erdy     = gg ? 2'b10 : 2'b01;
        acc[k]   = 1'b1;
        g[k]     = gg;
        mwe[k]   = w[gg];
        maddr[k] = gg ? a1 : a0;
        mwd[k]   = gg ? d1 : d0;
      end
      if (!rst) check($sformatf("u%0d.ready", k), rdy[k], erdy);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      S = sc(k);
      // jRAM contents follow the strobes of the cycle just ended, reset or not.
      if (ph[k] >= 1 && ph[k] <= S) begin
        if (mwe[k]) shadow[k][maddr[k]] = mwd[k];
        else if (ph[k] == S) mrdata[k] = shadow[k][maddr[k]];
      end
      if (sw[k] >= 0 && (sw[k] % (S + 1)) != 0) shadow[k][sw[k] / (S + 1)] = 8'h00;
      if (rst) begin
        ph[k] = -1; sw[k] = -1; clrp[k] = CLR; rr[k] = 1'b0;
        e_mar[k] = 8'h00; e_rspd[k] = 8'h00;
      end else begin
        if (acc[k]) ph[k] = 0;
        else if (ph[k] >= 0) begin
          ph[k]++;
          if (ph[k] > S + 1) ph[k] = -1;
        end
        if (ph[k] == S + 1) rr[k] = ~g[k];
        if (clrp[k]) begin
          clrp[k] = 1'b0; sw[k] = 0;
        end else if (sw[k] >= 0) begin
          sw[k]++;
          if (sw[k] == 256 * (S + 1)) sw[k] = -1;
        end
      end
      esa = 1'b0; es = 1'b0; ee = 1'b0; ebo = 8'h00; erv = 2'b00;
      if (ph[k] == 0) begin esa = 1'b1; e_mar[k] = maddr[k]; end
      if (ph[k] >= 1 && ph[k] <= S) begin
        if (mwe[k]) begin es = 1'b1; ebo = mwd[k]; end
        else ee = 1'b1;
      end
      if (ph[k] == S + 1) begin
        erv       = g[k] ? 2'b10 : 2'b01;
        e_rspd[k] = mwe[k] ? mwd[k] : mrdata[k];
      end
      if (sw[k] >= 0) begin
        e_mar[k] = 8'(sw[k] / (S + 1));
        if ((sw[k] % (S + 1)) == 0) esa = 1'b1;
        else es = 1'b1;
      end
      ebusy = (ph[k] >= 0) || (sw[k] >= 0);
      check($sformatf("u%0d.mar", k),       mar[k],  e_mar[k]);
      check($sformatf("u%0d.sa", k),        sa[k],   esa);
      check($sformatf("u%0d.s", k),         s[k],    es);
      check($sformatf("u%0d.e", k),         e[k],    ee);
      check($sformatf("u%0d.bus_out", k),   bo[k],   ebo);
      check($sformatf("u%0d.rsp_valid", k), rv[k],   erv);
      check($sformatf("u%0d.rsp_data", k),  rd[k],   e_rspd[k]);
      check($sformatf("u%0d.busy", k),      busy[k], ebusy);
    end
  endtask

  function automatic logic [7:0] pick_addr();
    logic [7:0] r;
    r = 8'($urandom);
    return ($urandom_range(0, 3) == 0) ? r : (8'h38 | (r & 8'h07));
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      ph[k] = -1; sw[k] = -1; clrp[k] = 1'b0; rr[k] = 1'b0; g[k] = 1'b0;
      mwe[k] = 1'b0; maddr[k] = 8'h00; mwd[k] = 8'h00; mrdata[k] = 8'h00;
      e_mar[k] = 8'h00; e_rspd[k] = 8'h00;
      for (int a = 0; a < 256; a++) shadow[k][a] = 8'(a * 37 + 11);
    end
    rst = 1'b1; v = 2'b00; w = 2'b00; a0 = 8'h00; a1 = 8'h00; d0 = 8'h00; d1 = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    if (CLR) repeat (256 * 4 + 4) tick();

    // req0 writes 0x3C <= 0xA5, then req1 reads it back.
    v = 2'b01; w = 2'b01; a0 = 8'h3C; d0 = 8'hA5;
    tick();
    v = 2'b00; repeat (8) tick();
    v = 2'b10; w = 2'b00; a1 = 8'h3C;
    tick();
    v = 2'b00; repeat (8) tick();

    // Both requesters continuously valid: grants must alternate.
    v = 2'b11; w = 2'b11; a0 = 8'h10; d0 = 8'h11; a1 = 8'h20; d1 = 8'h22;
    repeat (24) tick();
    v = 2'b00; repeat (8) tick();

    // Reset lands in the second strobe cycle, then a fresh req0 read.
    v = 2'b01; w = 2'b01; a0 = 8'h55; d0 = 8'h66;
    tick();
    v = 2'b00; tick(); tick();
    rst = 1'b1; tick();
    rst = 1'b0; v = 2'b01; w = 2'b00; a0 = 8'h3C;
    tick();
    v = 2'b00; repeat (8) tick();

    // Randomized traffic with occasional resets.
    repeat (NRAND) begin
      rst = ($urandom_range(0, RST_DEN - 1) == 0);
      v   = 2'($urandom);
      w   = 2'($urandom);
      a0  = pick_addr();
      a1  = pick_addr();
      d0  = 8'($urandom);
      d1  = 8'($urandom);
      tick();
    end
    rst = 1'b0; v = 2'b00;
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
